port_sched_arbiter: RTL and testbench
=====================================

# port_sched_arbiter

Packet-granular output-port scheduler for the shared-cache switch. One instance sits in front of each output port. It decides which of the `PORT_NUB_TOTAL` input ports may stream a packet out of the shared cache to that port, and holds the grant from first beat to `eop`. Arbitration is strict priority across levels and round-robin within the winning level. A watchdog frees the port if a granted stream stalls.

## Interface
Parameters:
- `PORT_NUB_TOTAL`, default 8: number of requesters; must be ≥ 2.
- `PRIORITY`, default 8: number of priority levels. Priority value 0 is lowest.
- `TIMEOUT`, default 1024: stall cycles before forced release. 0 disables the watchdog.
- `WIDTH_SEL`, derived as `$clog2(PORT_NUB_TOTAL)`.
- `WIDTH_PRIORITY`, derived as `$clog2(PRIORITY)`.

Ports:
- `clk`, input, 1: single clock (internal_clk domain).
- `rst_n`, input, 1: asynchronous active-low reset.
- `req`, input, PORT_NUB_TOTAL: per-input request. A requester holds it high while it has a packet queued for this port.
- `req_priority`, input, PORT_NUB_TOTAL*WIDTH_PRIORITY: priority of each requester's head packet. Requester i occupies slice [(i+1)*WIDTH_PRIORITY-1 : i*WIDTH_PRIORITY].
- `in_vld`, input, PORT_NUB_TOTAL: per-input beat valid.
- `in_eop`, input, PORT_NUB_TOTAL: per-input last-beat flag, qualified by `in_vld`.
- `ready`, input, 1: output port can accept a beat this cycle.
- `grant`, output, PORT_NUB_TOTAL: one-hot grant, registered.
- `grant_sel`, output, WIDTH_SEL: binary index of the granted requester. Drives the datapath mux.
- `busy`, output, 1: a grant is active.
- `pkt_cnt`, output, 16: count of completed packets. Wraps at 0xFFFF to 0.
- `timeout_pulse`, output, 1: one-cycle pulse on a forced release.

## Operation
- FSM states:
  - IDLE: no grant.
  - XFER: grant held.
- Beat handshake: `busy & in_vld[grant_sel] & ready`. `in_vld` and `in_eop` from non-granted inputs are ignored.
- Packet end: a handshake with `in_eop[grant_sel]` high.
- Arbitration function, evaluated combinationally each cycle:
  - Step 1: find `maxp`, the largest `req_priority` among inputs with `req` high.
  - Step 2: among requesters at `maxp`, pick the first index found by searching cyclically upward from `rr_ptr`.
- Transitions:
  - IDLE, with any `req` high: register the winner into `grant`/`grant_sel`, set `busy`, go to XFER. Set `rr_ptr` to winner+1 mod PORT_NUB_TOTAL.
  - XFER, on packet end:
    - increment `pkt_cnt`;
    - re-arbitrate in the same cycle using the already-advanced `rr_ptr`;
    - if any `req` is high, load the new winner and stay in XFER (no bubble). The just-finished requester is eligible again but ranks last within its level;
    - otherwise clear `grant` and go to IDLE.
  - XFER, on watchdog expiry: clear `grant`, go to IDLE, pulse `timeout_pulse`. `pkt_cnt` is not incremented and no re-arbitration happens that cycle.
- Grant is held regardless of `req` deasserting mid-packet. Only packet end or the watchdog releases it.
- Watchdog:
  - counter clears on grant load and on every handshake;
  - otherwise increments while in XFER;
  - expires when it reaches TIMEOUT-1;
  - with TIMEOUT=0 it never expires.
- `req_priority` values ≥ PRIORITY are treated as PRIORITY-1.

## Timing
- Reset (asynchronous, any state including mid-packet):
  - `grant`=0, `grant_sel`=0, `busy`=0, `pkt_cnt`=0, `timeout_pulse`=0;
  - `rr_ptr`=0, watchdog counter=0, FSM in IDLE.
- Grant latency: `req` high at edge t while in IDLE gives `grant` valid after edge t+1.
- Back-to-back: eop handshake at edge t gives the new `grant` after edge t+1. There is zero idle cycle between packets.
- `pkt_cnt` updates at the edge following the eop handshake.
- `timeout_pulse` is high for exactly the cycle after expiry.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Simultaneous packet end and watchdog expiry: packet end wins (a handshake clears the counter).

## Test plan
- Single request, beat count:
  - Stimulus: reset, then `req`=0b00000100, priority 1; 20-beat packet with `ready`=1.
  - Required: `grant`=0x04 and `grant_sel`=2 one cycle after `req`; grant holds for 20 beats; IDLE after eop; `pkt_cnt`=1.
- Round-robin rotation:
  - Stimulus: inputs 1, 3, 5 request continuously at equal priority; `rr_ptr`=0; each sends 4-beat packets.
  - Required: grant order 1, 3, 5, 1, 3, 5 with no bubble between packets; `pkt_cnt`=6.
- Strict priority:
  - Stimulus: input 0 requests at priority 1 and input 6 at priority 5, both raised in the same cycle.
  - Required: 6 is granted first, then 0.
  - Stimulus (continued): raise a priority-7 request on input 2 while 0 is mid-packet.
  - Required: no preemption; 2 is granted at 0's eop.
- Backpressure:
  - Stimulus: hold `ready`=0 for 100 cycles mid-packet (TIMEOUT=1024).
  - Required: grant stays on the same requester; no beats counted; transfer resumes when `ready`=1.
- Watchdog:
  - Stimulus: TIMEOUT=16; granted input stops asserting `in_vld`.
  - Required: `timeout_pulse` is high one cycle after 16 stalled cycles; `grant`=0; `pkt_cnt` unchanged; the next request is granted on the following cycle.
- Reset mid-packet:
  - Stimulus: assert `rst_n`=0 while in XFER.
  - Required: all outputs 0 immediately (asynchronous); after release, arbitration restarts from `rr_ptr`=0.

Source files
------------

// File: rtl/port_sched_arbiter.sv
// port_sched_arbiter: strict-priority, round-robin packet scheduler for one output port
module port_sched_arbiter #(
    parameter int PORT_NUB_TOTAL = 8,
    parameter int PRIORITY       = 8,
    parameter int TIMEOUT        = 1024,
    parameter int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL),
    parameter int WIDTH_PRIORITY = $clog2(PRIORITY)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [PORT_NUB_TOTAL-1:0]                req,
    input  logic [PORT_NUB_TOTAL*WIDTH_PRIORITY-1:0] req_priority,
    input  logic [PORT_NUB_TOTAL-1:0]                in_vld,
    input  logic [PORT_NUB_TOTAL-1:0]                in_eop,
    input  logic                                     ready,
    output logic [PORT_NUB_TOTAL-1:0]                grant,
    output logic [WIDTH_SEL-1:0]                     grant_sel,
    output logic                                     busy,
    output logic [15:0]                              pkt_cnt,
    output logic                                     timeout_pulse
);
    localparam int WD_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = TIMEOUT > 0 ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                    state_q, state_d;
    logic [PORT_NUB_TOTAL-1:0] grant_q, grant_d;
    logic [WIDTH_SEL-1:0]      grant_sel_q, grant_sel_d;
    logic                      busy_q, busy_d;
    logic [15:0]               pkt_cnt_q, pkt_cnt_d;
    logic                      timeout_pulse_q, timeout_pulse_d;
    logic [WIDTH_SEL-1:0]      rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]           wd_q, wd_d;

    logic [WIDTH_PRIORITY-1:0] prio [PORT_NUB_TOTAL];
    logic [WIDTH_PRIORITY-1:0] maxp;
    logic [WIDTH_SEL-1:0]      win, win_next, sel;
    logic                      found, hs, eop, expire, arb;
    int                        idx;

    assign hs       = busy_q & in_vld[grant_sel_q] & ready;
    assign eop      = hs & in_eop[grant_sel_q];
    assign expire   = (TIMEOUT != 0) && (wd_q == WD_MAX);
    assign arb      = (state_q == IDLE) || eop;
    assign win_next = (int'(win) == PORT_NUB_TOTAL - 1) ? '0 : win + 1'b1;

    // Winner: highest clamped priority, then first requester cyclically from rr_ptr
    always_comb begin
        maxp  = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = 0; i < PORT_NUB_TOTAL; i++) begin
            prio[i] = (int'(req_priority[i*WIDTH_PRIORITY +: WIDTH_PRIORITY]) >= PRIORITY)
                    ? WIDTH_PRIORITY'(PRIORITY - 1)
                    : req_priority[i*WIDTH_PRIORITY +: WIDTH_PRIORITY];
            if (req[i] && prio[i] > maxp) maxp = prio[i];
        end
        for (int k = 0; k < PORT_NUB_TOTAL; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= PORT_NUB_TOTAL) idx = idx - PORT_NUB_TOTAL;
            sel = WIDTH_SEL'(idx);
            if (!found && req[sel] && prio[sel] == maxp) begin
                found = 1'b1;
                win   = sel;
            end
        end
    end

    // Next state: load on idle or packet end, otherwise hold and run the watchdog
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        grant_sel_d     = grant_sel_q;
        busy_d          = busy_q;
        pkt_cnt_d       = eop ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
        timeout_pulse_d = 1'b0;
        rr_ptr_d        = rr_ptr_q;
        wd_d            = wd_q;
        if (arb && |req) begin
            state_d     = XFER;
            grant_d     = {{(PORT_NUB_TOTAL-1){1'b0}}, 1'b1} << win;
            grant_sel_d = win;
            busy_d      = 1'b1;
            rr_ptr_d    = win_next;
            wd_d        = '0;
        end else if (arb || (!hs && expire)) begin
            state_d         = IDLE;
            grant_d         = '0;
            grant_sel_d     = '0;
            busy_d          = 1'b0;
            wd_d            = '0;
            timeout_pulse_d = !arb;
        end else begin
            wd_d = hs ? '0 : wd_q + 1'b1;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            grant_sel_q     <= '0;
            busy_q          <= 1'b0;
            pkt_cnt_q       <= '0;
            timeout_pulse_q <= 1'b0;
            rr_ptr_q        <= '0;
            wd_q            <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            grant_sel_q     <= grant_sel_d;
            busy_q          <= busy_d;
            pkt_cnt_q       <= pkt_cnt_d;
            timeout_pulse_q <= timeout_pulse_d;
            rr_ptr_q        <= rr_ptr_d;
            wd_q            <= wd_d;
        end
    end

    assign grant         = grant_q;
    assign grant_sel     = grant_sel_q;
    assign busy          = busy_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign timeout_pulse = timeout_pulse_q;
endmodule

// File: tb/tb_port_sched_arbiter.sv
// tb_port_sched_arbiter: directed checks of grant, rotation, priority, backpressure, watchdog, reset
module tb_port_sched_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  req, in_vld, in_eop;
    logic [23:0] req_priority;
    logic        ready;

    logic [7:0]  grant, w_grant;
    logic [2:0]  grant_sel, w_grant_sel;
    logic        busy, w_busy, tmo, w_tmo;
    logic [15:0] pkt_cnt, w_pkt_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] rr_exp [6] = '{8'h02, 8'h08, 8'h20, 8'h02, 8'h08, 8'h20};

    always #5 clk = ~clk;

    port_sched_arbiter #(.PORT_NUB_TOTAL(8), .PRIORITY(8), .TIMEOUT(1024)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_priority(req_priority),
        .in_vld(in_vld), .in_eop(in_eop), .ready(ready),
        .grant(grant), .grant_sel(grant_sel), .busy(busy),
        .pkt_cnt(pkt_cnt), .timeout_pulse(tmo)
    );

    port_sched_arbiter #(.PORT_NUB_TOTAL(8), .PRIORITY(8), .TIMEOUT(16)) u_wd (
        .clk(clk), .rst_n(rst_n), .req(req), .req_priority(req_priority),
        .in_vld(in_vld), .in_eop(in_eop), .ready(ready),
        .grant(w_grant), .grant_sel(w_grant_sel), .busy(w_busy),
        .pkt_cnt(w_pkt_cnt), .timeout_pulse(w_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_prio(input int i, input logic [2:0] p);
        req_priority[i*3 +: 3] = p;
    endtask

    initial begin
        req = '0; req_priority = '0; in_vld = '0; in_eop = '0; ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sel", 32'(grant_sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pkt", 32'(pkt_cnt), 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);
        // single requester, 20-beat packet
        req = 8'h04; set_prio(2, 3'd1); ready = 1'b1;
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'h04);
        chk("t1_sel", 32'(grant_sel), 32'h2);
        chk("t1_busy", 32'(busy), 32'h1);
        for (int b = 0; b < 20; b++) begin
            in_vld = 8'h04;
            in_eop = (b == 19) ? 8'h04 : 8'h00;
            if (b == 19) req = 8'h00;
            @(negedge clk);
            if (b < 19) chk("t1_hold", 32'(grant), 32'h04);
            if (b == 18) chk("t1_pkt_mid", 32'(pkt_cnt), 32'h0);
        end
        in_vld = '0; in_eop = '0;
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_idle_grant", 32'(grant), 32'h0);
        chk("t1_pkt", 32'(pkt_cnt), 32'h1);
        // round robin among 1, 3, 5 from rr_ptr=0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'h2A; set_prio(1, 3'd2); set_prio(3, 3'd2); set_prio(5, 3'd2); in_vld = 8'h2A;
        @(negedge clk);
        for (int p = 0; p < 6; p++) begin
            for (int b = 0; b < 4; b++) begin
                if (b == 0) chk("rr_grant", 32'(grant), 32'(rr_exp[p]));
                in_eop = (b == 3) ? 8'h2A : 8'h00;
                if (p == 5 && b == 3) req = 8'h00;
                @(negedge clk);
            end
        end
        in_vld = '0; in_eop = '0;
        chk("rr_busy", 32'(busy), 32'h0);
        chk("rr_pkt", 32'(pkt_cnt), 32'h6);
        // strict priority, then no preemption
        req = 8'h41; set_prio(0, 3'd1); set_prio(6, 3'd5);
        @(negedge clk);
        chk("sp_first", 32'(grant), 32'h40);
        chk("sp_first_sel", 32'(grant_sel), 32'h6);
        in_vld = 8'h41;
        @(negedge clk);
        chk("sp_hold6", 32'(grant), 32'h40);
        in_eop = 8'h40; req = 8'h01;
        @(negedge clk);
        chk("sp_second", 32'(grant), 32'h01);
        chk("sp_second_sel", 32'(grant_sel), 32'h0);
        in_vld = 8'h01; in_eop = 8'h00;
        @(negedge clk);
        req = 8'h05; set_prio(2, 3'd7);
        @(negedge clk);
        chk("sp_no_preempt", 32'(grant), 32'h01);
        in_vld = 8'h05; in_eop = 8'h01; req = 8'h04;
        @(negedge clk);
        chk("sp_third", 32'(grant), 32'h04);
        chk("sp_third_sel", 32'(grant_sel), 32'h2);
        in_vld = 8'h04; in_eop = 8'h04; req = 8'h00;
        @(negedge clk);
        in_vld = '0; in_eop = '0;
        chk("sp_idle", 32'(busy), 32'h0);
        chk("sp_pkt", 32'(pkt_cnt), 32'h9);
        // backpressure for 100 cycles with eop pending
        req = 8'h08; set_prio(3, 3'd0);
        @(negedge clk);
        chk("bp_grant", 32'(grant), 32'h08);
        in_vld = 8'h08;
        @(negedge clk); @(negedge clk);
        ready = 1'b0; in_eop = 8'h08; req = 8'h00;
        repeat (50) @(negedge clk);
        chk("bp_mid_grant", 32'(grant), 32'h08);
        repeat (50) @(negedge clk);
        chk("bp_grant_held", 32'(grant), 32'h08);
        chk("bp_busy", 32'(busy), 32'h1);
        chk("bp_pkt", 32'(pkt_cnt), 32'h9);
        chk("bp_no_tmo", 32'(tmo), 32'h0);
        ready = 1'b1;
        @(negedge clk);
        in_vld = '0; in_eop = '0;
        chk("bp_resume_busy", 32'(busy), 32'h0);
        chk("bp_resume_pkt", 32'(pkt_cnt), 32'hA);
        // watchdog on the TIMEOUT=16 instance
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'h10; set_prio(4, 3'd3);
        @(negedge clk);
        chk("wd_grant", 32'(w_grant), 32'h10);
        chk("wd_tmo_early", 32'(w_tmo), 32'h0);
        repeat (15) @(negedge clk);
        chk("wd_grant_last", 32'(w_grant), 32'h10);
        chk("wd_tmo_last", 32'(w_tmo), 32'h0);
        req = 8'h30; set_prio(5, 3'd3);
        @(negedge clk);
        chk("wd_tmo", 32'(w_tmo), 32'h1);
        chk("wd_released", 32'(w_grant), 32'h0);
        chk("wd_busy", 32'(w_busy), 32'h0);
        chk("wd_pkt", 32'(w_pkt_cnt), 32'h0);
        chk("wd_long_no_tmo", 32'(tmo), 32'h0);
        chk("wd_long_grant", 32'(grant), 32'h10);
        in_vld = 8'h10; in_eop = 8'h10;
        @(negedge clk);
        chk("wd_regrant", 32'(w_grant), 32'h20);
        chk("wd_regrant_sel", 32'(w_grant_sel), 32'h5);
        chk("wd_tmo_clear", 32'(w_tmo), 32'h0);
        // asynchronous reset mid-packet
        in_vld = '0; in_eop = '0;
        @(negedge clk);
        chk("mr_pre_grant", 32'(grant), 32'h20);
        chk("mr_pre_pkt", 32'(pkt_cnt), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_grant", 32'(grant), 32'h0);
        chk("mr_sel", 32'(grant_sel), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_pkt", 32'(pkt_cnt), 32'h0);
        chk("mr_tmo", 32'(tmo), 32'h0);
        @(negedge clk);
        req = 8'h81; set_prio(0, 3'd2); set_prio(7, 3'd2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_restart_grant", 32'(grant), 32'h01);
        chk("mr_restart_sel", 32'(grant_sel), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
